// File: rtl/vnu_pkg.sv
// Shared types and arithmetic helpers for the serial variable-node unit.
package vnu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } vnu_state_t;

  // Width that holds llr + DEG messages with no overflow.
  function automatic int acc_width(input int w_llr, input int w_in, input int deg);
    int base;
    base = (w_llr > w_in + 1) ? w_llr : w_in + 1;
    return base + $clog2(deg + 1);
  endfunction

  // Clamp v into the two's-complement range of a w-bit signed value.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/vnu_serial_stream_if.sv
// Message stream bundle: upstream beats in (i_*), extrinsic/posterior beats out (o_*).
interface vnu_serial_stream_if #(
  parameter int W_IN  = 6,
  parameter int W_LLR = 9,
  parameter int W_OUT = 10
);
  logic                    i_valid;
  logic                    o_ready;
  logic                    i_first;
  logic signed [W_LLR-1:0] i_llr;
  logic [W_IN-1:0]         i_data;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [W_OUT-1:0] o_data;
  logic                    o_last;
  logic                    o_hard;

  modport master (
    output i_valid, i_first, i_llr, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_hard
  );

  modport slave (
    input  i_valid, i_first, i_llr, i_data, i_ready,
    output o_ready, o_valid, o_data, o_last, o_hard
  );
endinterface

// File: rtl/vnu_sm2tc.sv
// Sign-magnitude to two's-complement converter; passes data through when SM_IN=0.
module vnu_sm2tc #(
  parameter int W     = 6,
  parameter int SM_IN = 0
) (
  input  logic [W-1:0]        din,
  output logic signed [W-1:0] dout
);

  generate
    if (SM_IN != 0) begin : g_sm
      logic signed [W-1:0] mag;
      assign mag  = {1'b0, din[W-2:0]};
      // Negative zero falls out as zero since -0 == 0.
      assign dout = din[W-1] ? -mag : mag;
    end else begin : g_tc
      assign dout = din;
    end
  endgenerate

endmodule

// File: rtl/vnu_serial_stream.sv
// Serial VNU: loads DEG check messages plus channel LLR, then streams DEG
// extrinsic messages followed by the posterior with its hard decision.
module vnu_serial_stream
  import vnu_pkg::*;
#(
  parameter int DEG   = 4,
  parameter int W_IN  = 6,
  parameter int W_LLR = 9,
  parameter int W_OUT = 10,
  parameter int SM_IN = 0
) (
  input logic              clk,
  input logic              rst,
  vnu_serial_stream_if.slave s
);

  localparam int ACC_W = acc_width(W_LLR, W_IN, DEG);
  localparam int CNT_W = $clog2(DEG + 1);

  vnu_state_t state, state_nxt;

  logic [CNT_W-1:0]        in_cnt;
  logic [CNT_W-1:0]        out_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] buffer [DEG];

  logic signed [W_IN-1:0]  msg_tc;
  logic signed [ACC_W-1:0] msg_ext;
  logic signed [ACC_W-1:0] llr_ext;

  logic in_acc, out_acc;
  logic ld_first, ld_beat, emit_entry, emit_step, emit_done;

  logic [CNT_W-1:0]        ext_idx;
  logic signed [ACC_W-1:0] ext_acc;
  logic signed [ACC_W-1:0] ext_sel;
  logic signed [ACC_W-1:0] ext_val;
  logic signed [W_OUT-1:0] ext_out;
  logic signed [W_OUT-1:0] post_out;

  vnu_sm2tc #(.W(W_IN), .SM_IN(SM_IN)) u_sm2tc (
    .din  (s.i_data),
    .dout (msg_tc)
  );

  assign msg_ext   = ACC_W'(msg_tc);
  assign llr_ext   = ACC_W'(s.i_llr);
  assign s.o_ready = (state != EMIT);
  assign in_acc    = s.i_valid & s.o_ready;
  assign out_acc   = s.o_valid & s.i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ld_first   = 1'b0;
    ld_beat    = 1'b0;
    emit_entry = 1'b0;
    emit_step  = 1'b0;
    emit_done  = 1'b0;
    case (state)
      IDLE: begin
        if (in_acc && s.i_first) begin
          ld_first  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // A new first beat mid-node abandons the partial node and restarts.
        if (in_acc) begin
          if (s.i_first) begin
            ld_first = 1'b1;
          end else begin
            ld_beat = 1'b1;
            if (in_cnt == CNT_W'(DEG - 1)) begin
              emit_entry = 1'b1;
              state_nxt  = EMIT;
            end
          end
        end
      end
      EMIT: begin
        if (out_acc) begin
          if (s.o_last) begin
            emit_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            emit_step = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On EMIT entry the last message is still in flight, so fold it in here.
  assign ext_idx = emit_entry ? '0 : out_cnt + 1'b1;
  assign ext_acc = emit_entry ? acc + msg_ext : acc;

  always_comb begin
    ext_sel = '0;
    for (int i = 0; i < DEG; i++) begin
      if (ext_idx == CNT_W'(i)) ext_sel = buffer[i];
    end
  end

  assign ext_val  = ext_acc - ext_sel;
  assign ext_out  = W_OUT'(sat(64'(ext_val), W_OUT));
  assign post_out = W_OUT'(sat(64'(acc), W_OUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      acc      <= '0;
      s.o_valid <= 1'b0;
      s.o_data  <= '0;
      s.o_last  <= 1'b0;
      s.o_hard  <= 1'b0;
    end else begin
      if (ld_first) begin
        acc    <= llr_ext + msg_ext;
        in_cnt <= CNT_W'(1);
      end else if (ld_beat) begin
        acc    <= acc + msg_ext;
        in_cnt <= emit_entry ? '0 : in_cnt + 1'b1;
      end

      if (emit_entry) begin
        out_cnt   <= '0;
        s.o_valid <= 1'b1;
        s.o_data  <= ext_out;
        s.o_last  <= 1'b0;
        s.o_hard  <= 1'b0;
      end else if (emit_step) begin
        out_cnt <= out_cnt + 1'b1;
        if (ext_idx == CNT_W'(DEG)) begin
          s.o_data <= post_out;
          s.o_last <= 1'b1;
          s.o_hard <= acc[ACC_W-1];
        end else begin
          s.o_data <= ext_out;
        end
      end else if (emit_done) begin
        out_cnt   <= '0;
        s.o_valid <= 1'b0;
        s.o_last  <= 1'b0;
        s.o_hard  <= 1'b0;
      end
    end
  end

  // Message store: plain registers, contents are don't-care outside a node.
  always_ff @(posedge clk) begin
    if (ld_first) begin
      buffer[0] <= msg_ext;
    end else if (ld_beat) begin
      for (int i = 0; i < DEG; i++) begin
        if (in_cnt == CNT_W'(i)) buffer[i] <= msg_ext;
      end
    end
  end

endmodule
